// File: rtl/sound_request_scheduler_if.sv
// Sound request scheduler bus: request strobes/IDs in, PIO-facing sound controls and status out.
// Optional SOUND_SCHED_STATS_EN adds the drop_count status field.
interface sound_request_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 4
);
  logic [NUM_REQ-1:0]      req_stb;
  logic [NUM_REQ*ID_W-1:0] req_id;
  logic                    clr_overflow;
  logic [ID_W-1:0]         sound_id_out;
  logic                    start_sound_out;
  logic                    busy;
  logic [NUM_REQ-1:0]      pending;
  logic                    overflow;
`ifdef SOUND_SCHED_STATS_EN
  logic [7:0]              drop_count;

  modport master (
    output req_stb, req_id, clr_overflow,
    input  sound_id_out, start_sound_out, busy, pending, overflow, drop_count
  );

  modport slave (
    input  req_stb, req_id, clr_overflow,
    output sound_id_out, start_sound_out, busy, pending, overflow, drop_count
  );
`else
  modport master (
    output req_stb, req_id, clr_overflow,
    input  sound_id_out, start_sound_out, busy, pending, overflow
  );

  modport slave (
    input  req_stb, req_id, clr_overflow,
    output sound_id_out, start_sound_out, busy, pending, overflow
  );
`endif
endinterface

// File: rtl/sound_request_scheduler.sv
// Round-robin scheduler that sequences per-source sound requests onto a single
// sound_id / start_sound PIO pair: start is held START_HOLD cycles, then held low
// GAP_CYCLES cycles before the next grant.
// Define SOUND_SCHED_STATS_EN to add the saturating drop_count statistics output.
module sound_request_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned START_HOLD = 50000,
  parameter int unsigned GAP_CYCLES = 25000
) (
  input  logic                    clk50m,
  input  logic                    reset_n,
  sound_request_scheduler_if.slave bus
);

  localparam int unsigned MaxCnt = (START_HOLD > GAP_CYCLES) ? START_HOLD : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned PtrW   = $clog2(NUM_REQ);

  localparam logic [CntW-1:0] HoldLast = CntW'(START_HOLD - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [PtrW-1:0] LastIdx  = PtrW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StIdle, StAssert, StGap} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_out_q, id_out_d;
  logic [NUM_REQ-1:0]  pending_q, pending_d;
  logic [ID_W-1:0]     slot_id_q [NUM_REQ];
  logic [ID_W-1:0]     slot_id_d [NUM_REQ];
  logic                overflow_q, overflow_d;
  logic [NUM_REQ-1:0]  overwrite;

  logic                win_found;
  logic [PtrW-1:0]     win_idx;
  logic [PtrW-1:0]     cand;
  logic                grant;

  // Round-robin pick: first pending slot scanning upward from rr_ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PtrW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && pending_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant = (state_q == StIdle) && win_found;

  // Pending slots: the grant clears first, so a strobe on the granted source becomes a new request.
  always_comb begin
    pending_d = pending_q;
    slot_id_d = slot_id_q;
    overwrite = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant && (win_idx == PtrW'(i))) begin
        pending_d[i] = 1'b0;
      end
      // ID 0 means "no sound" and is ignored.
      if (bus.req_stb[i] && (bus.req_id[i*ID_W +: ID_W] != '0)) begin
        if (pending_d[i]) begin
          overwrite[i] = 1'b1;
        end
        pending_d[i] = 1'b1;
        slot_id_d[i] = bus.req_id[i*ID_W +: ID_W];
      end
    end
  end

  // Sticky overflow; a new overwrite beats a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (|overwrite) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Sequencer: IDLE grants, ASSERT holds start, GAP enforces the quiet time.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    id_out_d = id_out_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d  = StAssert;
          cnt_d    = '0;
          id_out_d = slot_id_q[win_idx];
          rr_ptr_d = (win_idx == LastIdx) ? '0 : win_idx + PtrW'(1);
        end
      end
      StAssert: begin
        if (cnt_q == HoldLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State, slot and status registers.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rr_ptr_q   <= '0;
      id_out_q   <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_id_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      id_out_q   <= id_out_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_id_q[i] <= slot_id_d[i];
      end
    end
  end

  assign bus.sound_id_out    = id_out_q;
  assign bus.start_sound_out = (state_q == StAssert);
  assign bus.busy            = (state_q != StIdle);
  assign bus.pending         = pending_q;
  assign bus.overflow        = overflow_q;

`ifdef SOUND_SCHED_STATS_EN
  logic [7:0] drop_q, drop_d;
  logic [8:0] drop_sum;

  // Count overwrites, saturating at 255; increment beats a simultaneous clear.
  always_comb begin
    drop_sum = 9'(drop_q) + 9'($countones(overwrite));
    drop_d   = drop_q;
    if (|overwrite) begin
      drop_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end else if (bus.clr_overflow) begin
      drop_d = '0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign bus.drop_count = drop_q;
`endif

endmodule

// File: tb/tb_sound_request_scheduler.sv
// Scoreboard bench for sound_request_scheduler: a transaction-level reference model
// predicts per-cycle status and the sequence of plays; a negedge monitor compares.
module tb_sound_request_scheduler;

  localparam int unsigned NR   = 4;
  localparam int unsigned IW   = 4;
  localparam int unsigned HOLD = 4;
  localparam int unsigned GAP  = 3;

  logic clk50m  = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk50m = ~clk50m;

  sound_request_scheduler_if #(.NUM_REQ(NR), .ID_W(IW)) bus_if ();

  sound_request_scheduler #(
    .NUM_REQ   (NR),
    .ID_W      (IW),
    .START_HOLD(HOLD),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk50m (clk50m),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  typedef struct {
    int            e;
    logic          start;
    logic          busy;
    logic [IW-1:0] id;
    logic [NR-1:0] pend;
    logic          ovf;
    logic [7:0]    drop;
  } exp_t;

  typedef struct {
    int            e;
    logic [IW-1:0] id;
  } play_t;

  exp_t  exp_q[$];
  play_t play_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  logic [NR-1:0] m_pend;
  logic [IW-1:0] m_id [NR];
  int            m_rr;
  int            m_free;
  int            m_g;
  logic [IW-1:0] m_cur;
  logic          m_ovf;
  int            m_drop;

  always @(posedge clk50m) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic void model_reset();
    m_pend = '0;
    for (int i = 0; i < NR; i++) m_id[i] = '0;
    m_rr   = 0;
    m_free = 0;
    m_g    = -1000;
    m_cur  = '0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endfunction

  function automatic void push_expect(input int e);
    exp_t x;
    x.e     = e;
    x.start = (e >= m_g) && (e < m_g + int'(HOLD));
    x.busy  = (e >= m_g) && (e < m_g + int'(HOLD + GAP));
    x.id    = m_cur;
    x.pend  = m_pend;
    x.ovf   = m_ovf;
    x.drop  = 8'(m_drop);
    exp_q.push_back(x);
  endfunction

  // One clock edge e of the reference: grant (if free) then capture strobes.
  function automatic void model_step(input int e, input logic [NR-1:0] stb,
                                     input logic [NR*IW-1:0] ids, input logic clr);
    int ow = 0;
    if (e >= m_free && m_pend != '0) begin
      for (int k = 0; k < NR; k++) begin
        int idx = (m_rr + k) % NR;
        if (m_pend[idx]) begin
          play_t p;
          m_cur       = m_id[idx];
          m_pend[idx] = 1'b0;
          m_rr        = (idx + 1) % NR;
          m_g         = e;
          m_free      = e + int'(HOLD + GAP) + 1;
          p.e         = e;
          p.id        = m_cur;
          play_q.push_back(p);
          break;
        end
      end
    end
    for (int i = 0; i < NR; i++) begin
      logic [IW-1:0] nid = ids[i*IW +: IW];
      if (stb[i] && nid != '0) begin
        if (m_pend[i]) ow++;
        m_pend[i] = 1'b1;
        m_id[i]   = nid;
      end
    end
    if (ow > 0) begin
      m_ovf  = 1'b1;
      m_drop = (m_drop + ow > 255) ? 255 : m_drop + ow;
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    push_expect(e);
  endfunction

  function automatic logic [NR*IW-1:0] ids4(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // Called at posedge+2; inputs are sampled by the next edge.
  task automatic drive(input logic [NR-1:0] stb, input logic [NR*IW-1:0] ids, input logic clr);
    bus_if.req_stb      = stb;
    bus_if.req_id       = ids;
    bus_if.clr_overflow = clr;
    model_step(cyc + 1, stb, ids, clr);
    @(posedge clk50m);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0, 1'b0);
  endtask

  task automatic reset_pulse(input int n);
    reset_n = 1'b0;
    bus_if.req_stb      = '0;
    bus_if.req_id       = '0;
    bus_if.clr_overflow = 1'b0;
    exp_q.delete();
    play_q.delete();
    model_reset();
    #1;
    check("rst_start", 32'(bus_if.start_sound_out), 32'(0));
    check("rst_id", 32'(bus_if.sound_id_out), 32'(0));
    check("rst_busy", 32'(bus_if.busy), 32'(0));
    check("rst_pending", 32'(bus_if.pending), 32'(0));
    check("rst_overflow", 32'(bus_if.overflow), 32'(0));
    repeat (n) @(posedge clk50m);
    #2;
    reset_n = 1'b1;
    push_expect(cyc);
  endtask

  // Monitor
  logic prev_start = 1'b0;
  int   hi_cnt     = 0;

  always @(negedge clk50m) begin
    if (!reset_n) begin
      prev_start = 1'b0;
      hi_cnt     = 0;
    end else begin
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        check("edge_align", 32'(cyc), 32'(x.e));
        check("start", 32'(bus_if.start_sound_out), 32'(x.start));
        check("busy", 32'(bus_if.busy), 32'(x.busy));
        check("sound_id", 32'(bus_if.sound_id_out), 32'(x.id));
        check("pending", 32'(bus_if.pending), 32'(x.pend));
        check("overflow", 32'(bus_if.overflow), 32'(x.ovf));
`ifdef SOUND_SCHED_STATS_EN
        check("drop_count", 32'(bus_if.drop_count), 32'(x.drop));
`endif
      end
      if (bus_if.start_sound_out && !prev_start) begin
        check("play_expected", 32'(play_q.size() != 0), 32'(1));
        if (play_q.size() != 0) begin
          play_t p;
          p = play_q.pop_front();
          check("play_id", 32'(bus_if.sound_id_out), 32'(p.id));
          check("play_cycle", 32'(cyc), 32'(p.e));
        end
        hi_cnt = 1;
      end else if (bus_if.start_sound_out) begin
        hi_cnt++;
      end else if (prev_start) begin
        check("hold_width", 32'(hi_cnt), 32'(HOLD));
      end
      prev_start = bus_if.start_sound_out;
    end
  end

  initial begin
    bus_if.req_stb      = '0;
    bus_if.req_id       = '0;
    bus_if.clr_overflow = 1'b0;
    @(posedge clk50m);
    #2;
    reset_pulse(2);
    idle(3);

    // Single request
    drive(4'b0100, ids4(0, 0, 5, 0), 1'b0);
    idle(12);

    // Simultaneous requests
    drive(4'b1011, ids4(1, 2, 0, 3), 1'b0);
    idle(28);

    // Fairness: source 0 re-requests while source 1 waits
    drive(4'b0011, ids4(7, 9, 0, 0), 1'b0);
    idle(1);
    drive(4'b0001, ids4(7, 0, 0, 0), 1'b0);
    idle(26);

    // Overwrite during another source's ASSERT, then clear
    drive(4'b1000, ids4(0, 0, 0, 2), 1'b0);
    idle(1);
    drive(4'b0010, ids4(0, 4, 0, 0), 1'b0);
    drive(4'b0010, ids4(0, 6, 0, 0), 1'b0);
    idle(20);
    drive('0, '0, 1'b1);
    idle(3);

    // ID 0 is ignored
    drive(4'b0100, ids4(0, 0, 0, 0), 1'b0);
    idle(5);

    // Strobe in the grant cycle of the same source
    drive(4'b0001, ids4(3, 0, 0, 0), 1'b0);
    drive(4'b0001, ids4(8, 0, 0, 0), 1'b0);
    idle(20);

    // Reset in the middle of ASSERT
    drive(4'b0010, ids4(0, 11, 0, 0), 1'b0);
    idle(2);
    reset_pulse(3);
    idle(10);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [NR-1:0]    stb;
      logic [NR*IW-1:0] ids;
      logic             clr;
      for (int i = 0; i < NR; i++) begin
        stb[i]          = ($urandom_range(0, 5) == 0);
        ids[i*IW +: IW] = IW'($urandom_range(0, 15));
      end
      clr = ($urandom_range(0, 19) == 0);
      drive(stb, ids, clr);
    end
    idle(45);

    @(negedge clk50m);
    #1;
    check("plays_drained", 32'(play_q.size()), 32'(0));
    check("expects_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
